// File: rtl/rv32m_pkg.sv
// RV32M operation encoding shared by the execute stage and the multi-cycle unit.
package rv32m_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } rv32m_op_t;

endpackage

// File: rtl/stage3_types_pkg.sv
// Types for the 3-stage pipeline: MDU sequencer state and result-cache entry.
package stage3_types_pkg;

  import rv32m_pkg::*;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } mdu_seq_state_t;

  typedef struct packed {
    logic        valid;
    rv32m_op_t   op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } mdu_cache_entry_t;

endpackage

// File: rtl/stage3_mdu_sequencer_if.sv
// Execute-stage request, functional-unit handshake and result signals of the MDU sequencer.
interface stage3_mdu_sequencer_if;

  logic                  req_valid;
  rv32m_pkg::rv32m_op_t  req_op;
  logic [31:0]           req_a;
  logic [31:0]           req_b;
  logic                  req_stall;
  logic                  flush;
  logic                  advance;

  logic                  fu_start;
  rv32m_pkg::rv32m_op_t  fu_op;
  logic [31:0]           fu_a;
  logic [31:0]           fu_b;
  logic                  fu_done;
  logic [31:0]           fu_out;

  logic                  res_valid;
  logic [31:0]           res_data;
  logic                  busy;
  logic                  timeout;

  // Pipeline and functional-unit side.
  modport master (
    output req_valid, req_op, req_a, req_b, req_stall, flush, advance, fu_done, fu_out,
    input  fu_start, fu_op, fu_a, fu_b, res_valid, res_data, busy, timeout
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_stall, flush, advance, fu_done, fu_out,
    output fu_start, fu_op, fu_a, fu_b, res_valid, res_data, busy, timeout
  );

endinterface

// File: rtl/mdu_result_cache.sv
// One-entry cache of the last completed {op, a, b} -> result; valid cleared only by reset.
module mdu_result_cache
  import rv32m_pkg::*;
  import stage3_types_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,   // synchronous
  input  logic        wr_en_i,
  input  rv32m_op_t   wr_op_i,
  input  logic [31:0] wr_a_i,
  input  logic [31:0] wr_b_i,
  input  logic [31:0] wr_res_i,
  input  rv32m_op_t   lk_op_i,
  input  logic [31:0] lk_a_i,
  input  logic [31:0] lk_b_i,
  output logic        hit_o,
  output logic [31:0] res_o
);

  mdu_cache_entry_t entry_d, entry_q;

  // Overwrite the single entry on every write.
  always_comb begin
    entry_d = entry_q;
    if (wr_en_i) begin
      entry_d.valid = 1'b1;
      entry_d.op    = wr_op_i;
      entry_d.a     = wr_a_i;
      entry_d.b     = wr_b_i;
      entry_d.res   = wr_res_i;
    end
  end

  // Entry storage with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign hit_o = entry_q.valid && (entry_q.op == lk_op_i) &&
                 (entry_q.a == lk_a_i) && (entry_q.b == lk_b_i);
  assign res_o = entry_q.res;

endmodule

// File: rtl/stage3_mdu_sequencer.sv
// Issues one start per RV32M instruction, tracks done, drains flushed work, and serves repeats
// of the last completed operation from a one-entry result cache.
module stage3_mdu_sequencer
  import rv32m_pkg::*;
  import stage3_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                    CLK,
  input logic                    nRST,
  stage3_mdu_sequencer_if.slave  bus
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  mdu_seq_state_t  state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            fu_start_d, fu_start_q;
  rv32m_op_t       fu_op_d, fu_op_q;
  logic [31:0]     fu_a_d, fu_a_q;
  logic [31:0]     fu_b_d, fu_b_q;
  logic            timeout_d, timeout_q;

  logic            issue;
  logic            cache_hit;
  logic [31:0]     cache_res;
  logic            cache_wr;
  logic            res_valid;
  logic [31:0]     res_data;

  assign issue = bus.req_valid && !bus.req_stall && !bus.flush;

  mdu_result_cache u_cache (
    .clk_i    (CLK),
    .rst_ni   (nRST),
    .wr_en_i  (cache_wr),
    .wr_op_i  (fu_op_q),
    .wr_a_i   (fu_a_q),
    .wr_b_i   (fu_b_q),
    .wr_res_i (bus.fu_out),
    .lk_op_i  (bus.req_op),
    .lk_a_i   (bus.req_a),
    .lk_b_i   (bus.req_b),
    .hit_o    (cache_hit),
    .res_o    (cache_res)
  );

  // Next state, start/operand latching, cache write and the combinational result path.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fu_start_d = 1'b0;
    fu_op_d    = fu_op_q;
    fu_a_d     = fu_a_q;
    fu_b_d     = fu_b_q;
    timeout_d  = timeout_q;
    cache_wr   = 1'b0;
    res_valid  = 1'b0;
    res_data   = '0;

    unique case (state_q)
      StIdle: begin
        // fu_done is ignored here, so a stale completion after reset has no effect.
        if (issue) begin
          if (cache_hit) begin
            res_valid = 1'b1;
            res_data  = cache_res;
          end else begin
            fu_start_d = 1'b1;
            fu_op_d    = bus.req_op;
            fu_a_d     = bus.req_a;
            fu_b_d     = bus.req_b;
            cnt_d      = '0;
            state_d    = StRun;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.fu_done) begin
          // Result is valid for the latched operands even when squashed.
          cache_wr = 1'b1;
          cnt_d    = '0;
          state_d  = StIdle;
          if (!bus.flush) begin
            res_valid = 1'b1;
            res_data  = bus.fu_out;
          end
        end else if (cnt_q == CntLast) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else if (bus.flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.fu_done) begin
          cache_wr = 1'b1;
          cnt_d    = '0;
          state_d  = StIdle;
        end else if (cnt_q == CntLast) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      fu_start_q <= 1'b0;
      fu_op_q    <= OpMul;
      fu_a_q     <= '0;
      fu_b_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fu_start_q <= fu_start_d;
      fu_op_q    <= fu_op_d;
      fu_a_q     <= fu_a_d;
      fu_b_q     <= fu_b_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.fu_start  = fu_start_q;
  assign bus.fu_op     = fu_op_q;
  assign bus.fu_a      = fu_a_q;
  assign bus.fu_b      = fu_b_q;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;
  assign bus.busy      = bus.req_valid && !res_valid;
  assign bus.timeout   = timeout_q;

endmodule
